// File: rtl/dmro_readout_scheduler.sv
// Word-rate readout scheduler: PRBS7 training after reset/retrain, then round-robin
// sharing of the 30-bit serializer word among NREQ requesters, with idle and periodic sync fill.
module dmro_readout_scheduler #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned PW           = 25,
  parameter int unsigned TRAIN_FRAMES = 1024,
  parameter int unsigned SYNC_PERIOD  = 256
) (
  input  logic               CLKWord,
  input  logic               RST,
  input  logic               ForceTrain,
  input  logic               ENScrCfg,
  input  logic [NREQ-1:0]    ReqValid,
  input  logic [NREQ*PW-1:0] ReqData,
  output logic [NREQ-1:0]    ReqReady,
  output logic [29:0]        DataOut,
  output logic               TestMode,
  output logic               ENScr,
  output logic               Training,
  output logic [15:0]        FrameCnt
);

  localparam int unsigned WORD_W = 30;
  localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW     = PTR_W + 1;
  localparam int unsigned TC_W   = (TRAIN_FRAMES > 1) ? $clog2(TRAIN_FRAMES) : 1;
  localparam int unsigned SC_W   = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;

  localparam logic [WORD_W-1:0] IDLE_WORD = 30'h05A5A5A5;
  localparam logic [11:0]       SYNC_MARK = 12'hFC5;

  typedef enum logic {
    ST_TRAIN = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [TC_W-1:0]   tcnt_q, tcnt_d;
  logic [SC_W-1:0]   sync_q, sync_d;
  logic [PTR_W-1:0]  rr_ptr, rr_d;
  logic [15:0]       frame_d;
  logic [WORD_W-1:0] data_d;
  logic [NREQ-1:0]   grant_c;

  logic              gnt_found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [CW-1:0]     cand;

  // Round-robin search: first valid requester at or after rr_ptr, modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!gnt_found && ReqValid[cand[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Next-state and slot selection.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    sync_d  = sync_q;
    rr_d    = rr_ptr;
    frame_d = FrameCnt;
    data_d  = '0;
    grant_c = '0;
    case (state_q)
      ST_TRAIN: begin
        sync_d  = '0;
        frame_d = '0;
        if (ForceTrain) begin
          tcnt_d = '0;
        end else if (tcnt_q == TC_W'(TRAIN_FRAMES - 1)) begin
          state_d = ST_RUN;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
      end
      ST_RUN: begin
        if (ForceTrain) begin
          state_d = ST_TRAIN;
          tcnt_d  = '0;
          sync_d  = '0;
          frame_d = '0;
          data_d  = IDLE_WORD;
        end else begin
          frame_d = FrameCnt + 16'd1;
          sync_d  = (sync_q == SC_W'(SYNC_PERIOD - 1)) ? '0 : sync_q + SC_W'(1);
          if (sync_q == SC_W'(SYNC_PERIOD - 1)) begin
            data_d = {2'b10, SYNC_MARK, FrameCnt};
          end else if (gnt_found) begin
            grant_c[gnt_idx] = 1'b1;
            data_d = {2'b01, 3'(gnt_idx), ReqData[gnt_idx*PW +: PW]};
            rr_d   = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          end else begin
            data_d = IDLE_WORD;
          end
        end
      end
      default: state_d = ST_TRAIN;
    endcase
  end

  assign ReqReady = grant_c;

  always_ff @(posedge CLKWord or posedge RST) begin
    if (RST) state_q <= ST_TRAIN;
    else     state_q <= state_d;
  end

  // Counters and registered serializer-side outputs.
  always_ff @(posedge CLKWord or posedge RST) begin
    if (RST) begin
      tcnt_q   <= '0;
      sync_q   <= '0;
      rr_ptr   <= '0;
      FrameCnt <= '0;
      DataOut  <= '0;
      TestMode <= 1'b1;
      ENScr    <= 1'b0;
      Training <= 1'b1;
    end else begin
      tcnt_q   <= tcnt_d;
      sync_q   <= sync_d;
      rr_ptr   <= rr_d;
      FrameCnt <= frame_d;
      DataOut  <= data_d;
      TestMode <= (state_d == ST_TRAIN);
      Training <= (state_d == ST_TRAIN);
      ENScr    <= (state_d == ST_RUN) & ENScrCfg;
    end
  end

endmodule

// File: tb/tb_dmro_readout_scheduler.sv
// Bench for dmro_readout_scheduler: reference model + DataOut scoreboard, a vector table
// for round-robin patterns, and directed sequences for training, sync, retrain and async reset.
module tb_dmro_readout_scheduler;

  localparam int NREQ = 4;
  localparam int PW   = 25;
  localparam int TRAIN_FRAMES = 1024;
  localparam int SYNC_PERIOD  = 256;
  localparam logic [29:0] IDLE = 30'h05A5A5A5;

  logic               CLKWord = 1'b0;
  logic               RST;
  logic               ForceTrain;
  logic               ENScrCfg;
  logic [NREQ-1:0]    ReqValid;
  logic [NREQ*PW-1:0] ReqData;
  logic [NREQ-1:0]    ReqReady;
  logic [29:0]        DataOut;
  logic               TestMode;
  logic               ENScr;
  logic               Training;
  logic [15:0]        FrameCnt;

  dmro_readout_scheduler #(
    .NREQ(NREQ), .PW(PW), .TRAIN_FRAMES(TRAIN_FRAMES), .SYNC_PERIOD(SYNC_PERIOD)
  ) dut (
    .CLKWord(CLKWord), .RST(RST), .ForceTrain(ForceTrain), .ENScrCfg(ENScrCfg),
    .ReqValid(ReqValid), .ReqData(ReqData), .ReqReady(ReqReady), .DataOut(DataOut),
    .TestMode(TestMode), .ENScr(ENScr), .Training(Training), .FrameCnt(FrameCnt)
  );

  always #5 CLKWord = ~CLKWord;

  int n_vec = 0;
  int n_err = 0;

  logic [PW-1:0] payload [NREQ];
  logic [29:0]   sb_q [$];

  bit          m_run;
  int          m_tcnt, m_sync, m_rr;
  logic [15:0] m_frame;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  g;
    logic [29:0] d;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_tcnt = 0; m_sync = 0; m_rr = 0; m_frame = '0;
    sb_q.delete();
  endtask

  // One word slot: drive at negedge, check grant, predict, clock, check outputs.
  task automatic run_cycle(input logic [NREQ-1:0] v, input logic ft,
                           output logic [NREQ-1:0] got_g, output logic [29:0] got_d);
    logic [NREQ-1:0] eg;
    logic [29:0]     ed, sd;
    logic            eens, found;
    int              idx, nrr;
    ReqValid = v;
    ForceTrain = ft;
    #1;
    eg = '0; found = 1'b0; nrr = m_rr;
    if (!m_run) ed = 30'h0;
    else if (ft) ed = IDLE;
    else if (m_sync == SYNC_PERIOD - 1) ed = {2'b10, 12'hFC5, m_frame};
    else begin
      ed = IDLE;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (!found && v[idx]) begin
          found = 1'b1;
          eg[idx] = 1'b1;
          ed = {2'b01, 3'(idx), payload[idx]};
          nrr = (idx + 1) % NREQ;
        end
      end
    end
    m_rr = nrr;
    got_g = ReqReady;
    chk("req_ready", 32'(got_g), 32'(eg));
    sb_q.push_back(ed);
    if (!m_run) begin
      m_sync = 0; m_frame = '0;
      if (ft) m_tcnt = 0;
      else if (m_tcnt == TRAIN_FRAMES - 1) begin m_run = 1'b1; m_tcnt = 0; end
      else m_tcnt++;
    end else if (ft) begin
      m_run = 1'b0; m_tcnt = 0; m_sync = 0; m_frame = '0;
    end else begin
      m_frame = m_frame + 16'd1;
      m_sync = (m_sync == SYNC_PERIOD - 1) ? 0 : m_sync + 1;
    end
    eens = m_run & ENScrCfg;
    @(posedge CLKWord);
    #1;
    got_d = DataOut;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      sd = sb_q.pop_front();
      chk("data_out", 32'(got_d), 32'(sd));
    end
    chk("test_mode", 32'(TestMode), 32'(!m_run));
    chk("training", 32'(Training), 32'(!m_run));
    chk("enscr", 32'(ENScr), 32'(eens));
    chk("frame_cnt", 32'(FrameCnt), 32'(m_frame));
    @(negedge CLKWord);
  endtask

  // Run until TestMode drops (bounded); returns the number of edges taken.
  task automatic train_len(input logic [NREQ-1:0] v, output int n);
    logic [NREQ-1:0] g;
    logic [29:0]     d;
    bit              done;
    n = 0; done = 1'b0;
    for (int i = 0; i < TRAIN_FRAMES + 80 && !done; i++) begin
      run_cycle(v, 1'b0, g, d);
      n++;
      if (TestMode == 1'b0) done = 1'b1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] g, prev_g;
    logic [29:0]     d;
    int              n;
    bit              hit;

    payload[0] = 25'h0000AAA;
    payload[1] = 25'h1111111;
    payload[2] = 25'h1ABCDEF;
    payload[3] = 25'h0F0F0F0;
    for (int i = 0; i < NREQ; i++) ReqData[i*PW +: PW] = payload[i];

    // Starting state: rr=0, sync=1 (after the first idle RUN slot).
    tbl[0]  = '{4'hF, 4'b0001, 30'h10000AAA};
    tbl[1]  = '{4'hF, 4'b0010, 30'h13111111};
    tbl[2]  = '{4'hF, 4'b0100, 30'h15ABCDEF};
    tbl[3]  = '{4'hF, 4'b1000, 30'h16F0F0F0};
    tbl[4]  = '{4'hF, 4'b0001, 30'h10000AAA};
    tbl[5]  = '{4'b0100, 4'b0100, 30'h15ABCDEF};
    tbl[6]  = '{4'b0100, 4'b0100, 30'h15ABCDEF};
    tbl[7]  = '{4'b0000, 4'b0000, 30'h05A5A5A5};
    tbl[8]  = '{4'b0011, 4'b0001, 30'h10000AAA};
    tbl[9]  = '{4'b1001, 4'b1000, 30'h16F0F0F0};
    tbl[10] = '{4'b1010, 4'b0010, 30'h13111111};
    tbl[11] = '{4'b0001, 4'b0001, 30'h10000AAA};
    tbl[12] = '{4'hF, 4'b0010, 30'h13111111};

    RST = 1'b1; ForceTrain = 1'b0; ENScrCfg = 1'b1; ReqValid = '0;
    model_reset();
    @(negedge CLKWord);
    #1;
    chk("rst_data", 32'(DataOut), 32'h0);
    chk("rst_testmode", 32'(TestMode), 32'd1);
    chk("rst_enscr", 32'(ENScr), 32'd0);
    chk("rst_training", 32'(Training), 32'd1);
    chk("rst_ready", 32'(ReqReady), 32'd0);
    chk("rst_frame", 32'(FrameCnt), 32'd0);
    @(negedge CLKWord);
    RST = 1'b0;

    // Training length after reset release, then the first RUN slot is idle.
    train_len(4'hF, n);
    chk("train_len_reset", 32'(n), 32'd1024);
    run_cycle(4'h0, 1'b0, g, d);
    chk("first_idle", 32'(d), 32'h05A5A5A5);

    for (int i = 0; i < 13; i++) begin
      run_cycle(tbl[i].v, 1'b0, g, d);
      chk("tbl_grant", 32'(g), 32'(tbl[i].g));
      chk("tbl_data", 32'(d), 32'(tbl[i].d));
    end

    // All valid until the first sync slot (FrameCnt 255), then RR resumes.
    hit = 1'b0; prev_g = '0;
    for (int i = 0; i < 300 && !hit; i++) begin
      run_cycle(4'hF, 1'b0, g, d);
      if (d[29:28] == 2'b10) hit = 1'b1;
      else prev_g = g;
    end
    chk("sync_seen", 32'(hit), 32'd1);
    chk("sync_grant", 32'(g), 32'd0);
    chk("sync_word", 32'(d), 32'h2FC500FF);
    run_cycle(4'hF, 1'b0, g, d);
    chk("rr_resume", 32'(g), 32'({prev_g[2:0], prev_g[3]}));

    // Retrain request: no grant, idle word, full training again, held while ForceTrain=1.
    run_cycle(4'hF, 1'b1, g, d);
    chk("ft_grant", 32'(g), 32'd0);
    chk("ft_idle", 32'(d), 32'(IDLE));
    chk("ft_training", 32'(Training), 32'd1);
    for (int i = 0; i < 5; i++) run_cycle(4'hF, 1'b1, g, d);
    train_len(4'hF, n);
    chk("train_len_force", 32'(n), 32'd1024);
    chk("frame_after_train", 32'(FrameCnt), 32'd0);

    // Random traffic across a sync slot.
    for (int i = 0; i < 300; i++) begin
      ENScrCfg = 1'($urandom);
      run_cycle(4'($urandom_range(0, 15)), 1'b0, g, d);
    end
    ENScrCfg = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle(4'hF, 1'b0, g, d);

    // Asynchronous reset between edges.
    ReqValid = 4'hF;
    #2;
    RST = 1'b1;
    #1;
    chk("arst_data", 32'(DataOut), 32'h0);
    chk("arst_testmode", 32'(TestMode), 32'd1);
    chk("arst_enscr", 32'(ENScr), 32'd0);
    chk("arst_training", 32'(Training), 32'd1);
    chk("arst_ready", 32'(ReqReady), 32'd0);
    chk("arst_frame", 32'(FrameCnt), 32'd0);
    @(negedge CLKWord);
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) run_cycle(4'hF, 1'b0, g, d);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
